// File: rtl/xsm_record_reader.sv
// Consumer end of the XSM capture stream: queues 128-bit capture records and
// serializes each one as four 32-bit words on a valid/ready stream.
module xsm_record_reader #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DEPTH        = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]    sample_data,
    input  logic [47:0]                mono_counter,
    input  logic [63:0]                timestamp,
    input  logic                       rd_en,
    input  logic                       clr_ovf,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [31:0]                m_data,
    output logic                       m_last,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       ovf,
    output logic [15:0]                drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FULL_LEVEL = FW'(DEPTH);

    logic [127:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q,   fill_d;
    logic [1:0]    idx_q,    idx_d;
    logic          ovf_q,    ovf_d;
    logic [15:0]   drop_q,   drop_d;

    logic          full;
    logic          push;
    logic          drop;
    logic          hs;
    logic          pop;
    logic [15:0]   sample_ext;
    logic [127:0]  record;
    logic [127:0]  head;
    logic [31:0]   head_word;

    assign sample_ext = 16'(sample_data);
    assign record     = {mono_counter[47:32], sample_ext, mono_counter[31:0], timestamp};

    // Fullness is judged on the registered level, so a same-edge pop never frees a slot.
    assign full = (fill_q == FULL_LEVEL);
    assign push = sample_valid && rd_en && !full;
    assign drop = sample_valid && rd_en && full;
    assign hs   = m_valid && m_ready;
    assign pop  = hs && (idx_q == 2'd3);

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        head_word = 32'd0;
        case (idx_q)
            2'd0: head_word = head[127:96];
            2'd1: head_word = head[95:64];
            2'd2: head_word = head[63:32];
            2'd3: head_word = head[31:0];
            default: head_word = 32'd0;
        endcase
    end

    assign m_valid    = (fill_q != '0);
    assign m_data     = m_valid ? head_word : 32'd0;
    assign m_last     = m_valid && (idx_q == 2'd3);
    assign fill_level = fill_q;
    assign ovf        = ovf_q;
    assign drop_cnt   = drop_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (hs) begin
            idx_d = idx_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (pop && !push) begin
            fill_d = fill_q - 1'b1;
        end

        // A drop on the clearing edge still counts, leaving a count of one.
        if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = 16'd0;
        end
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = clr_ovf ? 16'd1 : ((drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= record;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            idx_q    <= 2'd0;
            ovf_q    <= 1'b0;
            drop_q   <= 16'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_xsm_record_reader.sv
// Directed bench for xsm_record_reader: reset, serialization, backpressure,
// overflow, same-edge events, gating/wrap and reset in the middle of a record.
module tb_xsm_record_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic [47:0] mono_counter;
    logic [63:0] timestamp;
    logic        rd_en;
    logic        clr_ovf;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic [3:0]  fill_level;
    logic        ovf;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    xsm_record_reader #(.SAMPLE_WIDTH(16), .DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .mono_counter (mono_counter),
        .timestamp    (timestamp),
        .rd_en        (rd_en),
        .clr_ovf      (clr_ovf),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .fill_level   (fill_level),
        .ovf          (ovf),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Distinct per-record field values, indexed by record number n.
    function automatic logic [47:0] cnt_of(input int n);
        return {16'hA000 + 16'(n), 32'h1000_0000 + 32'(n)};
    endfunction
    function automatic logic [15:0] smp_of(input int n);
        return 16'h0100 + 16'(n);
    endfunction
    function automatic logic [63:0] ts_of(input int n);
        return {32'hB000_0000 + 32'(n), 32'hC000_0000 + 32'(n)};
    endfunction
    function automatic logic [31:0] word_of(input int n, input int w);
        logic [47:0] c;
        logic [63:0] t;
        c = cnt_of(n);
        t = ts_of(n);
        case (w)
            0:       return {c[47:32], smp_of(n)};
            1:       return c[31:0];
            2:       return t[63:32];
            default: return t[31:0];
        endcase
    endfunction

    task automatic set_strobe(input int n);
        sample_valid = 1'b1;
        sample_data  = smp_of(n);
        mono_counter = cnt_of(n);
        timestamp    = ts_of(n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_stream m_valid=%b m_last=%b m_data=%h expected 0/0/0", m_valid, m_last, m_data);
        end
        checks++;
        if (fill_level !== 4'd0 || ovf !== 1'b0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_status fill=%0d ovf=%b drop=%0d expected 0/0/0", fill_level, ovf, drop_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h1234_1000;
        exp_w[1] = 32'h5678_9ABC;
        exp_w[2] = 32'h0011_2233;
        exp_w[3] = 32'h4455_6677;
        m_ready      = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 16'h1000;
        mono_counter = 48'h0000_1234_5678_9ABC;
        timestamp    = 64'h0011_2233_4455_6677;
        tick();
        sample_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_w[w] || m_last !== (w == 3)) begin
                failures++;
                $display("FAIL basic_w%0d valid=%b data=%h last=%b expected 1/%h/%b", w, m_valid, m_data, m_last, exp_w[w], w == 3);
            end
            if (w == 0) begin
                checks++;
                if (fill_level !== 4'd1) begin
                    failures++;
                    $display("FAIL basic_fill1 fill=%0d expected 1", fill_level);
                end
            end
            tick();
        end
        checks++;
        if (fill_level !== 4'd0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_empty fill=%0d valid=%b expected 0/0", fill_level, m_valid);
        end
        $display("test_basic done");
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w [4];
        logic        pat [7];
        int          k;
        exp_w[0] = 32'h1234_1000;
        exp_w[1] = 32'h5678_9ABC;
        exp_w[2] = 32'h0011_2233;
        exp_w[3] = 32'h4455_6677;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        k = 0;
        m_ready      = 1'b0;
        sample_valid = 1'b1;
        sample_data  = 16'h1000;
        mono_counter = 48'h0000_1234_5678_9ABC;
        timestamp    = 64'h0011_2233_4455_6677;
        tick();
        sample_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            m_ready = pat[i];
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_w[k] || m_last !== (k == 3)) begin
                failures++;
                $display("FAIL bp_cycle%0d valid=%b data=%h last=%b expected 1/%h/%b", i, m_valid, m_data, m_last, exp_w[k], k == 3);
            end
            tick();
            if (pat[i]) k++;
        end
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || fill_level !== 4'd0) begin
            failures++;
            $display("FAIL bp_done valid=%b fill=%0d expected 0/0 after 4 handshakes", m_valid, fill_level);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            set_strobe(n);
            tick();
        end
        sample_valid = 1'b0;
        checks++;
        if (fill_level !== 4'd8 || ovf !== 1'b1 || drop_cnt !== 16'd2) begin
            failures++;
            $display("FAIL ovf_status fill=%0d ovf=%b drop=%0d expected 8/1/2", fill_level, ovf, drop_cnt);
        end
        m_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            for (int w = 0; w < 4; w++) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== word_of(n, w)) begin
                    failures++;
                    $display("FAIL ovf_drain_r%0d_w%0d valid=%b data=%h expected 1/%h", n, w, m_valid, m_data, word_of(n, w));
                end
                tick();
            end
        end
        checks++;
        if (m_valid !== 1'b0 || fill_level !== 4'd0) begin
            failures++;
            $display("FAIL ovf_drained valid=%b fill=%0d expected 0/0", m_valid, fill_level);
        end
        m_ready = 1'b0;
        $display("test_overflow done");
    endtask

    task automatic test_simultaneous();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL sim_clear ovf=%b drop=%0d expected 0/0", ovf, drop_cnt);
        end
        m_ready = 1'b0;
        for (int n = 20; n < 28; n++) begin
            set_strobe(n);
            tick();
        end
        sample_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        // W3 handshake and a strobe on the same edge while full
        checks++;
        if (m_last !== 1'b1 || fill_level !== 4'd8) begin
            failures++;
            $display("FAIL sim_pre_pop last=%b fill=%0d expected 1/8", m_last, fill_level);
        end
        set_strobe(40);
        tick();
        sample_valid = 1'b0;
        m_ready = 1'b0;
        checks++;
        if (fill_level !== 4'd7 || ovf !== 1'b1 || drop_cnt !== 16'd1) begin
            failures++;
            $display("FAIL sim_pop_drop fill=%0d ovf=%b drop=%0d expected 7/1/1", fill_level, ovf, drop_cnt);
        end
        set_strobe(41);
        tick();
        set_strobe(42);
        tick();
        checks++;
        if (fill_level !== 4'd8 || drop_cnt !== 16'd2) begin
            failures++;
            $display("FAIL sim_refill fill=%0d drop=%0d expected 8/2", fill_level, drop_cnt);
        end
        set_strobe(43);
        clr_ovf = 1'b1;
        tick();
        sample_valid = 1'b0;
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b1 || drop_cnt !== 16'd1) begin
            failures++;
            $display("FAIL sim_clr_drop ovf=%b drop=%0d expected 1/1", ovf, drop_cnt);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        m_ready = 1'b0;
        checks++;
        if (ovf !== 1'b0 || drop_cnt !== 16'd0 || fill_level !== 4'd0) begin
            failures++;
            $display("FAIL sim_final ovf=%b drop=%0d fill=%0d expected 0/0/0", ovf, drop_cnt, fill_level);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_gating_wrap();
        int bad;
        rd_en   = 1'b0;
        m_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            set_strobe(60 + n);
            tick();
        end
        sample_valid = 1'b0;
        checks++;
        if (fill_level !== 4'd0 || drop_cnt !== 16'd0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL gate_ignored fill=%0d drop=%0d valid=%b expected 0/0/0", fill_level, drop_cnt, m_valid);
        end
        rd_en = 1'b1;
        bad = 0;
        for (int c = 0; c <= 80; c++) begin
            if (c < 80 && (c % 4) == 0) set_strobe(100 + c / 4);
            else sample_valid = 1'b0;
            if (c >= 1) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== word_of(100 + (c - 1) / 4, (c - 1) % 4)
                    || m_last !== (((c - 1) % 4) == 3)) begin
                    failures++;
                    bad++;
                    $display("FAIL wrap_word%0d valid=%b data=%h last=%b expected 1/%h/%b", c - 1, m_valid, m_data,
                             m_last, word_of(100 + (c - 1) / 4, (c - 1) % 4), ((c - 1) % 4) == 3);
                end
            end
            tick();
        end
        checks++;
        if (fill_level !== 4'd0 || ovf !== 1'b0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end fill=%0d ovf=%b valid=%b expected 0/0/0", fill_level, ovf, m_valid);
        end
        $display("test_gating_wrap done (%0d word errors)", bad);
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_strobe(200 + n);
            tick();
        end
        sample_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        checks++;
        if (m_data !== word_of(200, 2) || fill_level !== 4'd3) begin
            failures++;
            $display("FAIL mid_pre data=%h fill=%0d expected %h/3", m_data, fill_level, word_of(200, 2));
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'd0 || fill_level !== 4'd0
            || ovf !== 1'b0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset valid=%b last=%b data=%h fill=%0d ovf=%b drop=%0d expected all 0",
                     m_valid, m_last, m_data, fill_level, ovf, drop_cnt);
        end
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_idle%0d valid=%b expected 0", i, m_valid);
            end
        end
        set_strobe(210);
        tick();
        sample_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== word_of(210, 0) || fill_level !== 4'd1) begin
            failures++;
            $display("FAIL mid_restart valid=%b data=%h fill=%0d expected 1/%h/1", m_valid, m_data, fill_level, word_of(210, 0));
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = 16'd0;
        mono_counter = 48'd0;
        timestamp    = 64'd0;
        rd_en        = 1'b1;
        clr_ovf      = 1'b0;
        m_ready      = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_simultaneous();
        test_gating_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
